// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, funct codes,
// ALU operations, instruction classes, FSM states and the decoder payload.
package mips_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned OPCODE_W = 6;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_LB    = 6'b100000;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_SB    = 6'b101000;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

    // R-type funct field values interpreted by the ALU when alu_op is ALU_FUNCT
    typedef enum logic [5:0] {
        FN_ADD = 6'h20,
        FN_SUB = 6'h22,
        FN_AND = 6'h24,
        FN_OR  = 6'h25,
        FN_SLT = 6'h2a
    } funct_e;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_AND   = 3'd2,
        ALU_OR    = 3'd3,
        ALU_SLT   = 3'd4,
        ALU_FUNCT = 3'd7
    } alu_op_e;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_ADDI,
        CLS_LOAD,
        CLS_STORE,
        CLS_BEQ,
        CLS_JUMP,
        CLS_ILLEGAL
    } instr_class_e;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC_R,
        ST_EXEC_I,
        ST_MEM_ADDR,
        ST_MEM_RD,
        ST_MEM_WR,
        ST_WB_R,
        ST_WB_I,
        ST_WB_MEM,
        ST_BRANCH,
        ST_JUMP,
        ST_HALT
    } state_e;

    typedef struct packed {
        instr_class_e     cls;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] write_reg;
        alu_op_e          alu_op;
        logic             alu_src_b;
        logic             byte_op;
    } decode_t;

endpackage

// File: rtl/mips_opcode_decoder.sv
// Combinational instruction decode: class, register fields, ALU op, byte flag.
module mips_opcode_decoder
    import mips_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output decode_t            dec
);

    // Immediate/target bits are consumed by the datapath, not by control.
    logic unused_imm;
    assign unused_imm = ^instr[10:0];

    // Map opcode to class and per-class control fields; unknown opcodes are illegal.
    always_comb begin
        dec           = '0;
        dec.cls       = CLS_ILLEGAL;
        dec.alu_op    = ALU_ADD;
        dec.rs        = instr[25:21];
        dec.rt        = instr[20:16];
        unique case (instr[31:26])
            OP_RTYPE: begin
                dec.cls       = CLS_R;
                dec.write_reg = instr[15:11];
                dec.alu_op    = ALU_FUNCT;
            end
            OP_ADDI: begin
                dec.cls       = CLS_ADDI;
                dec.write_reg = instr[20:16];
                dec.alu_src_b = 1'b1;
            end
            OP_LW, OP_LB: begin
                dec.cls       = CLS_LOAD;
                dec.write_reg = instr[20:16];
                dec.alu_src_b = 1'b1;
                dec.byte_op   = (instr[31:26] == OP_LB);
            end
            OP_SW, OP_SB: begin
                dec.cls       = CLS_STORE;
                dec.alu_src_b = 1'b1;
                dec.byte_op   = (instr[31:26] == OP_SB);
            end
            OP_BEQ: begin
                dec.cls    = CLS_BEQ;
                dec.alu_op = ALU_SUB;
            end
            OP_J: begin
                dec.cls = CLS_JUMP;
            end
            default: begin
                dec.cls = CLS_ILLEGAL;
            end
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle control FSM feeding the register file, memory, ALU and PC.
// ir_load and pc_write complete same-cycle handshakes (mem_ready, alu_zero),
// so they are decoded from the registered state; every other output is a
// register loaded from the next-state decode.
module mips_multicycle_control
    import mips_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr,
    input  logic               alu_zero,
    input  logic               mem_ready,
    output logic               ir_load,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic [REG_W-1:0]   read_reg1,
    output logic [REG_W-1:0]   read_reg2,
    output logic [REG_W-1:0]   write_reg,
    output logic               regWrite,
    output logic               byteOperations,
    output logic [2:0]         alu_op,
    output logic               alu_src_b,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic               fault,
    output logic [CNT_W-1:0]   retired
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_e            state, next_state;
    instr_class_e      cls_q, cls_d;
    decode_t           dec;
    logic [WAIT_W-1:0] wait_cnt, wait_d;
    logic              access_done, retire;

    logic [1:0]        pc_src_d;
    logic [REG_W-1:0]  read_reg1_d, read_reg2_d, write_reg_d;
    logic              regwrite_d, byte_d, alu_src_b_d;
    logic [2:0]        alu_op_d;
    logic              mem_read_d, mem_write_d, mem_to_reg_d, fault_d;
    logic [CNT_W-1:0]  retired_d;

    mips_opcode_decoder u_decoder (
        .instr (instr),
        .dec   (dec)
    );

    // State, wait counter, retired counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_FETCH;
            cls_q          <= CLS_ILLEGAL;
            wait_cnt       <= '0;
            pc_src         <= '0;
            read_reg1      <= '0;
            read_reg2      <= '0;
            write_reg      <= '0;
            regWrite       <= 1'b0;
            byteOperations <= 1'b0;
            alu_op         <= '0;
            alu_src_b      <= 1'b0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_to_reg     <= 1'b0;
            fault          <= 1'b0;
            retired        <= '0;
        end else begin
            state          <= next_state;
            cls_q          <= cls_d;
            wait_cnt       <= wait_d;
            pc_src         <= pc_src_d;
            read_reg1      <= read_reg1_d;
            read_reg2      <= read_reg2_d;
            write_reg      <= write_reg_d;
            regWrite       <= regwrite_d;
            byteOperations <= byte_d;
            alu_op         <= alu_op_d;
            alu_src_b      <= alu_src_b_d;
            mem_read       <= mem_read_d;
            mem_write      <= mem_write_d;
            mem_to_reg     <= mem_to_reg_d;
            fault          <= fault_d;
            retired        <= retired_d;
        end
    end

    // Next state, handshake strobes, memory timeout and next register values.
    always_comb begin
        next_state  = state;
        cls_d       = cls_q;
        wait_d      = '0;
        ir_load     = 1'b0;
        pc_write    = 1'b0;
        retire      = 1'b0;
        read_reg1_d = read_reg1;
        read_reg2_d = read_reg2;
        write_reg_d = write_reg;
        byte_d      = byteOperations;
        alu_op_d    = alu_op;
        alu_src_b_d = alu_src_b;

        // The strobe is low in the first FETCH cycle after reset, so ready is ignored there.
        access_done = mem_ready && (mem_read || mem_write);

        unique case (state)
            ST_FETCH: begin
                if (access_done) begin
                    ir_load    = 1'b1;
                    pc_write   = 1'b1;
                    next_state = ST_DECODE;
                end
            end
            ST_DECODE: begin
                unique case (dec.cls)
                    CLS_R:             next_state = ST_EXEC_R;
                    CLS_ADDI:          next_state = ST_EXEC_I;
                    CLS_LOAD, CLS_STORE: next_state = ST_MEM_ADDR;
                    CLS_BEQ:           next_state = ST_BRANCH;
                    CLS_JUMP:          next_state = ST_JUMP;
                    default:           next_state = ST_HALT;
                endcase
            end
            ST_EXEC_R:   next_state = ST_WB_R;
            ST_EXEC_I:   next_state = ST_WB_I;
            ST_MEM_ADDR: next_state = (cls_q == CLS_LOAD) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD: begin
                if (access_done) next_state = ST_WB_MEM;
            end
            ST_MEM_WR: begin
                if (access_done) begin
                    next_state = ST_FETCH;
                    retire     = 1'b1;
                end
            end
            ST_WB_R, ST_WB_I, ST_WB_MEM: begin
                next_state = ST_FETCH;
                retire     = 1'b1;
            end
            ST_BRANCH: begin
                pc_write   = alu_zero;
                next_state = ST_FETCH;
                retire     = 1'b1;
            end
            ST_JUMP: begin
                pc_write   = 1'b1;
                next_state = ST_FETCH;
                retire     = 1'b1;
            end
            ST_HALT:  next_state = ST_HALT;
            default:  next_state = ST_HALT;
        endcase

        // Count stalled memory cycles; the count restarts whenever the state changes.
        if ((state inside {ST_FETCH, ST_MEM_RD, ST_MEM_WR}) &&
            (mem_read || mem_write) && !mem_ready) begin
            if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                next_state = ST_HALT;
            end else begin
                wait_d = wait_cnt + WAIT_W'(1);
            end
        end

        // Decode fields are captured once and held for the rest of the instruction.
        if (state == ST_DECODE) begin
            cls_d       = dec.cls;
            read_reg1_d = dec.rs;
            read_reg2_d = dec.rt;
            write_reg_d = dec.write_reg;
            byte_d      = dec.byte_op;
            alu_op_d    = dec.alu_op;
            alu_src_b_d = dec.alu_src_b;
        end else if (next_state == ST_FETCH) begin
            byte_d      = 1'b0;
            alu_op_d    = ALU_ADD;
            alu_src_b_d = 1'b0;
        end

        mem_read_d   = (next_state == ST_FETCH) || (next_state == ST_MEM_RD);
        mem_write_d  = (next_state == ST_MEM_WR);
        mem_to_reg_d = (next_state == ST_MEM_RD) || (next_state == ST_WB_MEM);
        regwrite_d   = (next_state inside {ST_WB_R, ST_WB_I, ST_WB_MEM}) &&
                       (write_reg != '0);
        pc_src_d     = (next_state == ST_BRANCH) ? 2'd1 :
                       (next_state == ST_JUMP)   ? 2'd2 : 2'd0;
        fault_d      = fault || (next_state == ST_HALT);
        retired_d    = retired + CNT_W'(retire);
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for the multicycle control FSM.
module tb_mips_multicycle_control;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        alu_zero;
    logic        mem_ready;
    logic        ir_load;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [4:0]  write_reg;
    logic        regWrite;
    logic        byteOperations;
    logic [2:0]  alu_op;
    logic        alu_src_b;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        fault;
    logic [31:0] retired;

    int checks   = 0;
    int failures = 0;

    mips_multicycle_control #(
        .MEM_TIMEOUT (15),
        .CNT_W       (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr          (instr),
        .alu_zero       (alu_zero),
        .mem_ready      (mem_ready),
        .ir_load        (ir_load),
        .pc_write       (pc_write),
        .pc_src         (pc_src),
        .read_reg1      (read_reg1),
        .read_reg2      (read_reg2),
        .write_reg      (write_reg),
        .regWrite       (regWrite),
        .byteOperations (byteOperations),
        .alu_op         (alu_op),
        .alu_src_b      (alu_src_b),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_to_reg     (mem_to_reg),
        .fault          (fault),
        .retired        (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; leaves time just past the edge for driving and sampling.
    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    // Present an instruction in FETCH with memory ready this cycle.
    task automatic fetch(input logic [31:0] word);
        instr     = word;
        mem_ready = 1'b1;
        #1;
        chk("fetch_ir_load", 32'(ir_load), 32'd1);
        cycle();
        mem_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        instr     = 32'h0;
        alu_zero  = 1'b0;
        mem_ready = 1'b0;

        // Reset state
        cycle();
        cycle();
        #1;
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_fault",    32'(fault),    32'd0);
        chk("rst_retired",  retired,       32'd0);
        chk("rst_strobes",  32'({ir_load, pc_write, regWrite, mem_write}), 32'd0);

        // First FETCH after reset: strobe still low, ready is ignored
        rst_n     = 1'b1;
        instr     = 32'h00221820;
        mem_ready = 1'b1;
        #1;
        chk("post_rst_ir_load", 32'(ir_load), 32'd0);
        cycle();
        #1;
        chk("add_c1_mem_read", 32'(mem_read), 32'd1);
        chk("add_c1_pc_write", 32'(pc_write), 32'd1);
        chk("add_c1_pc_src",   32'(pc_src),   32'd0);

        // add $3,$1,$2
        fetch(32'h00221820);
        #1;
        chk("add_c2_mem_read", 32'(mem_read), 32'd0);
        chk("add_c2_pc_write", 32'(pc_write), 32'd0);
        cycle();
        chk("add_c3_rr1",      32'(read_reg1), 32'd1);
        chk("add_c3_rr2",      32'(read_reg2), 32'd2);
        chk("add_c3_alu_op",   32'(alu_op),    32'd7);
        chk("add_c3_regwrite", 32'(regWrite),  32'd0);
        cycle();
        chk("add_c4_regwrite", 32'(regWrite),  32'd1);
        chk("add_c4_wr",       32'(write_reg), 32'd3);
        chk("add_c4_retired",  retired,        32'd0);
        cycle();
        chk("add_c5_regwrite", 32'(regWrite),  32'd0);
        chk("add_c5_retired",  retired,        32'd1);
        chk("add_c5_mem_read", 32'(mem_read),  32'd1);

        // lb $5,4($1)
        fetch(32'h80250004);
        cycle();
        chk("lb_c3_byte",     32'(byteOperations), 32'd1);
        chk("lb_c3_srcb",     32'(alu_src_b),      32'd1);
        chk("lb_c3_alu_op",   32'(alu_op),         32'd0);
        chk("lb_c3_mem_read", 32'(mem_read),       32'd0);
        cycle();
        mem_ready = 1'b1;
        #1;
        chk("lb_c4_mem_read", 32'(mem_read),   32'd1);
        chk("lb_c4_m2r",      32'(mem_to_reg), 32'd1);
        cycle();
        mem_ready = 1'b0;
        chk("lb_c5_regwrite", 32'(regWrite),       32'd1);
        chk("lb_c5_wr",       32'(write_reg),      32'd5);
        chk("lb_c5_m2r",      32'(mem_to_reg),     32'd1);
        chk("lb_c5_byte",     32'(byteOperations), 32'd1);
        cycle();
        chk("lb_c6_regwrite", 32'(regWrite),       32'd0);
        chk("lb_c6_byte",     32'(byteOperations), 32'd0);
        chk("lb_c6_retired",  retired,             32'd2);

        // sw $2,8($1) with memory ready on the fourth MEM_WR cycle
        fetch(32'hAC220008);
        cycle();
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (i == 3) mem_ready = 1'b1;
            #1;
            chk("sw_mem_write", 32'(mem_write), 32'd1);
            chk("sw_no_regwr",  32'(regWrite),  32'd0);
            chk("sw_retired_hold", retired,     32'd2);
        end
        cycle();
        mem_ready = 1'b0;
        chk("sw_done_mem_write", 32'(mem_write), 32'd0);
        chk("sw_done_retired",   retired,        32'd3);

        // beq taken
        fetch(32'h10220003);
        cycle();
        alu_zero = 1'b1;
        #1;
        chk("beq_t_pc_write", 32'(pc_write), 32'd1);
        chk("beq_t_pc_src",   32'(pc_src),   32'd1);
        chk("beq_t_alu_op",   32'(alu_op),   32'd1);
        cycle();
        alu_zero = 1'b0;
        chk("beq_t_retired", retired, 32'd4);

        // beq not taken
        fetch(32'h10220003);
        cycle();
        #1;
        chk("beq_nt_pc_write", 32'(pc_write), 32'd0);
        cycle();
        chk("beq_nt_retired", retired, 32'd5);

        // j
        fetch(32'h08000010);
        cycle();
        #1;
        chk("j_pc_write", 32'(pc_write), 32'd1);
        chk("j_pc_src",   32'(pc_src),   32'd2);
        cycle();
        chk("j_retired", retired, 32'd6);

        // addi $0,$1,5: r0 write suppressed, still retires
        fetch(32'h20200005);
        cycle();
        cycle();
        chk("addi_r0_regwrite", 32'(regWrite), 32'd0);
        cycle();
        chk("addi_r0_retired", retired, 32'd7);

        // lw $4,0($1), reset while waiting in MEM_RD
        fetch(32'h8C240000);
        cycle();
        cycle();
        chk("lw_mem_read", 32'(mem_read), 32'd1);
        cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("rst_rd_mem_read", 32'(mem_read), 32'd0);
        chk("rst_rd_retired",  retired,       32'd0);
        chk("rst_rd_fault",    32'(fault),    32'd0);
        cycle();
        chk("rst_rd_mem_read_again", 32'(mem_read), 32'd1);

        // Illegal opcode -> HALT, sticky fault, no strobes
        fetch(32'hFC000000);
        cycle();
        chk("illegal_fault", 32'(fault), 32'd1);
        mem_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("halt_no_strobes",
                32'({ir_load, pc_write, regWrite, mem_read, mem_write}), 32'd0);
            cycle();
        end
        chk("halt_fault_sticky", 32'(fault), 32'd1);

        // Memory timeout in FETCH
        mem_ready = 1'b0;
        rst_n     = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("to_rst_fault", 32'(fault), 32'd0);
        cycle();
        chk("to_mem_read", 32'(mem_read), 32'd1);
        for (int i = 0; i < 14; i++) begin
            cycle();
            chk("to_wait_fault", 32'(fault), 32'd0);
        end
        cycle();
        chk("to_fault",    32'(fault),    32'd1);
        chk("to_mem_read_off", 32'(mem_read), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
